te_mult_scheduler: RTL and testbench

TE_MULT_SCHEDULER -- requirements
Module: te_mult_scheduler

---
 rtl/te_mult_scheduler.sv | 157 +++++++++++++++
 tb/tb_te_mult_scheduler.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/te_mult_scheduler.sv
// Transmission-estimate multiplier scheduler: time-multiplexes one external multiplier
// over the R/G/B channels of a pixel and reports the minimum product and its channel.
module te_mult_scheduler #(
    parameter int PC_W   = 8,
    parameter int AINV_W = 16,
    parameter int PROD_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_load,
    input  logic [AINV_W-1:0] cfg_ac_inv_r,
    input  logic [AINV_W-1:0] cfg_ac_inv_g,
    input  logic [AINV_W-1:0] cfg_ac_inv_b,
    output logic              cfg_ready,
    input  logic              in_valid,
    input  logic [PC_W-1:0]   pc_r,
    input  logic [PC_W-1:0]   pc_g,
    input  logic [PC_W-1:0]   pc_b,
    output logic              in_ready,
    output logic [PC_W-1:0]   mul_pc,
    output logic [AINV_W-1:0] mul_ac_inv,
    input  logic [PROD_W-1:0] mul_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] t_min,
    output logic [1:0]        t_ch
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL_R = 3'd1,
        MUL_G = 3'd2,
        MUL_B = 3'd3,
        DRAIN = 3'd4,
        OUT   = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic [PC_W-1:0]   pc_r_q, pc_g_q, pc_b_q;
    logic [AINV_W-1:0] ac_inv_r_q, ac_inv_g_q, ac_inv_b_q;
    logic [PROD_W-1:0] run_min;
    logic [1:0]        run_ch;
    logic              accept;
    logic              cfg_accept;
    logic              prod_less;

    assign accept     = in_valid & in_ready;
    assign cfg_accept = cfg_load & cfg_ready;
    assign prod_less  = (mul_product < run_min);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = MUL_R;
            MUL_R:   state_nxt = MUL_G;
            MUL_G:   state_nxt = MUL_B;
            MUL_B:   state_nxt = DRAIN;
            DRAIN:   state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ready outputs are gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        cfg_ready  = rst_n & (state == IDLE);
        in_ready   = rst_n & (state == IDLE) & ~cfg_load;
        mul_pc     = '0;
        mul_ac_inv = '0;
        case (state)
            MUL_R: begin
                mul_pc     = pc_r_q;
                mul_ac_inv = ac_inv_r_q;
            end
            MUL_G: begin
                mul_pc     = pc_g_q;
                mul_ac_inv = ac_inv_g_q;
            end
            MUL_B: begin
                mul_pc     = pc_b_q;
                mul_ac_inv = ac_inv_b_q;
            end
            default: begin
                mul_pc     = '0;
                mul_ac_inv = '0;
            end
        endcase
    end

    // Operand storage: config only changes in IDLE, so it is frozen across a sequence.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r_q     <= '0;
            pc_g_q     <= '0;
            pc_b_q     <= '0;
            ac_inv_r_q <= '1;
            ac_inv_g_q <= '1;
            ac_inv_b_q <= '1;
        end else begin
            if (cfg_accept) begin
                ac_inv_r_q <= cfg_ac_inv_r;
                ac_inv_g_q <= cfg_ac_inv_g;
                ac_inv_b_q <= cfg_ac_inv_b;
            end
            if (accept) begin
                pc_r_q <= pc_r;
                pc_g_q <= pc_g;
                pc_b_q <= pc_b;
            end
        end
    end

    // Products arrive one state late: R in MUL_G, G in MUL_B, B in DRAIN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_min   <= '0;
            run_ch    <= 2'd0;
            t_min     <= '0;
            t_ch      <= 2'd0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                MUL_G: begin
                    run_min <= mul_product;
                    run_ch  <= 2'd0;
                end
                MUL_B: begin
                    if (prod_less) begin
                        run_min <= mul_product;
                        run_ch  <= 2'd1;
                    end
                end
                DRAIN: begin
                    t_min     <= prod_less ? mul_product : run_min;
                    t_ch      <= prod_less ? 2'd2 : run_ch;
                    out_valid <= 1'b1;
                end
                OUT: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: begin
                    run_min <= run_min;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_te_mult_scheduler.sv
// Self-checking bench for te_mult_scheduler with a behavioural multiplier and min model.
module tb_te_mult_scheduler;
    localparam int PC_W   = 8;
    localparam int AINV_W = 16;
    localparam int PROD_W = 14;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_load;
    logic [AINV_W-1:0] cfg_ac_inv_r, cfg_ac_inv_g, cfg_ac_inv_b;
    logic              cfg_ready;
    logic              in_valid;
    logic [PC_W-1:0]   pc_r, pc_g, pc_b;
    logic              in_ready;
    logic [PC_W-1:0]   mul_pc;
    logic [AINV_W-1:0] mul_ac_inv;
    logic [PROD_W-1:0] mul_product;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] t_min;
    logic [1:0]        t_ch;

    int n_assert = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;
    int m_ai [3];

    te_mult_scheduler #(.PC_W(PC_W), .AINV_W(AINV_W), .PROD_W(PROD_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load),
        .cfg_ac_inv_r(cfg_ac_inv_r), .cfg_ac_inv_g(cfg_ac_inv_g), .cfg_ac_inv_b(cfg_ac_inv_b),
        .cfg_ready(cfg_ready), .in_valid(in_valid), .pc_r(pc_r), .pc_g(pc_g), .pc_b(pc_b),
        .in_ready(in_ready), .mul_pc(mul_pc), .mul_ac_inv(mul_ac_inv), .mul_product(mul_product),
        .out_valid(out_valid), .out_ready(out_ready), .t_min(t_min), .t_ch(t_ch)
    );

    always #5 clk = ~clk;

    function automatic int prod_of(input int pc, input int ai);
        int unsigned p;
        p = int'(pc) * (ai >> 2);
        return int'(p % (1 << PROD_W));
    endfunction

    // External multiplier with one cycle of latency, plus handshake counter.
    always @(posedge clk) begin
        mul_product <= PROD_W'(prod_of(int'(mul_pc), int'(mul_ac_inv)));
        if (out_valid && out_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic ref_model(input int r, input int g, input int b, output int tmin, output int tch);
        int pcs [3];
        int p;
        pcs  = '{r, g, b};
        tmin = prod_of(pcs[0], m_ai[0]);
        tch  = 0;
        for (int i = 1; i < 3; i++) begin
            p = prod_of(pcs[i], m_ai[i]);
            if (p < tmin) begin
                tmin = p;
                tch  = i;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input int r, input int g, input int b);
        cfg_load     = 1'b1;
        cfg_ac_inv_r = AINV_W'(r);
        cfg_ac_inv_g = AINV_W'(g);
        cfg_ac_inv_b = AINV_W'(b);
        #1;
        check("cfg_ready_idle", 32'(cfg_ready), 1);
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        m_ai = '{r, g, b};
    endtask

    task automatic run_txn(input int r, input int g, input int b, input int hold, input bit cfg_mid);
        int cnt, lat, exp_min, exp_ch, hs0;
        bit ir_bad, stab_bad, ir_hold_bad;
        int pcs [3];
        pcs = '{r, g, b};
        ref_model(r, g, b, exp_min, exp_ch);
        in_valid  = 1'b1;
        pc_r      = PC_W'(r);
        pc_g      = PC_W'(g);
        pc_b      = PC_W'(b);
        out_ready = 1'b0;
        #1;
        cnt = 0;
        while (!in_ready && cnt < 20) begin
            @(posedge clk);
            #2;
            cnt++;
        end
        check("accept_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        pc_r = PC_W'($urandom);
        pc_g = PC_W'($urandom);
        pc_b = PC_W'($urandom);
        hs0 = hs_cnt;
        lat = 1;
        ir_bad = 1'b0;
        while (!out_valid && lat < 20) begin
            if (in_ready) ir_bad = 1'b1;
            if (lat <= 3) begin
                check("mul_pc_seq", 32'(mul_pc), pcs[lat-1]);
                check("mul_ac_inv_seq", 32'(mul_ac_inv), m_ai[lat-1]);
            end
            if (cfg_mid && lat == 3) begin
                cfg_load     = 1'b1;
                cfg_ac_inv_r = 16'h1234;
                cfg_ac_inv_g = 16'h0001;
                cfg_ac_inv_b = 16'h0002;
                check("cfg_ready_busy", 32'(cfg_ready), 0);
            end else begin
                cfg_load = 1'b0;
            end
            tick();
            lat++;
        end
        cfg_load = 1'b0;
        check("latency", lat, 5);
        check("in_ready_busy", 32'(ir_bad), 0);
        check("t_min", 32'(t_min), exp_min);
        check("t_ch", 32'(t_ch), exp_ch);
        check("mul_pc_out", 32'(mul_pc), 0);
        stab_bad = 1'b0;
        ir_hold_bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (t_min !== PROD_W'(exp_min) || t_ch !== 2'(exp_ch) || out_valid !== 1'b1) stab_bad = 1'b1;
            if (in_ready !== 1'b0) ir_hold_bad = 1'b1;
        end
        check("hold_stable", 32'(stab_bad), 0);
        check("hold_in_ready", 32'(ir_hold_bad), 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_clr", 32'(out_valid), 0);
        check("hs_count", hs_cnt - hs0, 1);
        check("idle_in_ready", 32'(in_ready), 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        bit ov_bad;
        rst_n = 1'b0; cfg_load = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cfg_ac_inv_r = '0; cfg_ac_inv_g = '0; cfg_ac_inv_b = '0;
        pc_r = '0; pc_g = '0; pc_b = '0;
        m_ai = '{32'hFFFF, 32'hFFFF, 32'hFFFF};
        @(posedge clk);
        tick();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_cfg_ready", 32'(cfg_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_t_min", 32'(t_min), 0);
        check("rst_t_ch", 32'(t_ch), 0);
        check("rst_mul_pc", 32'(mul_pc), 0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 1);
        check("rel_cfg_ready", 32'(cfg_ready), 1);
        tick();

        // Reset-value Ac_Inv (all ones) used before any configuration.
        run_txn(3, 2, 1, 0, 1'b0);

        // Basic minimum and tie.
        do_cfg(16'h0100, 16'h0100, 16'h0100);
        run_txn(100, 50, 200, 0, 1'b0);
        check("basic_t_min_const", 32'(t_min), 3200);
        run_txn(10, 10, 10, 1, 1'b0);
        check("tie_t_min_const", 32'(t_min), 640);

        // Back-pressure for 7 cycles in OUT.
        run_txn(200, 150, 30, 7, 1'b0);

        // Config and pixel presented together: config wins.
        cfg_load = 1'b1;
        cfg_ac_inv_r = 16'h0100; cfg_ac_inv_g = 16'h0100; cfg_ac_inv_b = 16'h0040;
        in_valid = 1'b1;
        pc_r = 8'd100; pc_g = 8'd50; pc_b = 8'd200;
        #1;
        check("sim_in_ready", 32'(in_ready), 0);
        check("sim_cfg_ready", 32'(cfg_ready), 1);
        tick();
        cfg_load = 1'b0;
        m_ai = '{32'h0100, 32'h0100, 32'h0040};
        run_txn(100, 50, 200, 0, 1'b0);
        check("sim_t_ch_const", 32'(t_ch), 1);

        // cfg_load during MUL_B is ignored; following transaction still uses old values.
        run_txn(77, 91, 33, 0, 1'b1);
        run_txn(120, 240, 60, 2, 1'b0);

        // Reset while in MUL_G discards the in-flight triple.
        in_valid = 1'b1;
        pc_r = 8'd5; pc_g = 8'd6; pc_b = 8'd7;
        #1;
        check("rmg_accept", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check("rmg_in_ready", 32'(in_ready), 0);
        check("rmg_out_valid", 32'(out_valid), 0);
        rst_n = 1'b1;
        #1;
        check("rmg_rel_in_ready", 32'(in_ready), 1);
        hs0 = hs_cnt;
        ov_bad = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid !== 1'b0) ov_bad = 1'b1;
        end
        out_ready = 1'b0;
        check("rmg_no_output", 32'(ov_bad), 0);
        check("rmg_no_hs", hs_cnt - hs0, 0);
        m_ai = '{32'hFFFF, 32'hFFFF, 32'hFFFF};
        run_txn(200, 255, 130, 0, 1'b0);

        // Randomized traffic with occasional reconfiguration.
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 3) == 0)
                do_cfg(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                       int'($urandom_range(0, 65535)));
            run_txn(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
